// File: rtl/kgp_pkg.sv
// Shared definitions for the operand-issue slice: register-file geometry,
// ALU op-code constants and the output-stage state type.
package kgp_pkg;

    localparam int NREG  = 32;
    localparam int REG_W = 5;
    localparam int XLEN  = 32;

    // ALU op codes carried through to ALUopsel untouched
    localparam logic [4:0] ALU_PASS     = 5'b00000;
    localparam logic [4:0] ALU_ADD      = 5'b00001;
    localparam logic [4:0] ALU_ADD_NC   = 5'b00101;
    localparam logic [4:0] ALU_AND      = 5'b00010;
    localparam logic [4:0] ALU_XOR      = 5'b00011;
    localparam logic [4:0] ALU_SHL      = 5'b01000;
    localparam logic [4:0] ALU_SHR      = 5'b01001;
    localparam logic [4:0] ALU_SRA      = 5'b01010;
    localparam logic [4:0] ALU_ROT      = 5'b01011;
    localparam logic [4:0] ALU_DIFF     = 5'b10111;

    // Shifts occupy the whole 010xx group
    function automatic logic is_shift(input logic [4:0] op);
        return op[4:2] == 3'b010;
    endfunction

    // Output stage: one register, either holding an operation or not
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } issue_state_t;

endpackage

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports with
// write-through from the same-cycle write port; register 0 is hard zero.
module reg_file
    import kgp_pkg::*;
#(
    parameter int NREG = kgp_pkg::NREG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] raddr_a,
    output logic [XLEN-1:0]  rdata_a,
    input  logic [REG_W-1:0] raddr_b,
    output logic [XLEN-1:0]  rdata_b,
    input  logic             wen,
    input  logic [REG_W-1:0] waddr,
    input  logic [XLEN-1:0]  wdata
);

    logic [XLEN-1:0] mem [NREG];

    // Synchronous write, async clear; writes to register 0 are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (wen && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports: zero for r0, bypass the in-flight write, else array
    always_comb begin
        rdata_a = mem[raddr_a];
        rdata_b = mem[raddr_b];
        if (wen && waddr != '0 && waddr == raddr_a) rdata_a = wdata;
        if (wen && waddr != '0 && waddr == raddr_b) rdata_b = wdata;
        if (raddr_a == '0) rdata_a = '0;
        if (raddr_b == '0) rdata_b = '0;
    end

endmodule

// File: rtl/operand_issue.sv
// Operand issue stage: reads sources from the register file, tracks
// outstanding destination writes in a pending scoreboard, and hands
// operands to the ALU through a one-entry output register.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is combinational and does not depend on in_valid;
// out_valid comes straight from the output-stage state register, and the
// ALU-side outputs are held stable while out_valid && !out_ready.
module operand_issue
    import kgp_pkg::*;
#(
    parameter int NREG = kgp_pkg::NREG
) (
    input  logic             clk,
    input  logic             rst_n,
    // decode side
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [REG_W-1:0] in_rs,
    input  logic [REG_W-1:0] in_rt,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_use_imm,
    input  logic [4:0]       in_aluop,
    input  logic             in_alusel,
    input  logic [REG_W-1:0] in_rd,
    input  logic             in_wen,
    // writeback side
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    // ALU side
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  ALU_A,
    output logic [XLEN-1:0]  ALU_B,
    output logic             ALUipsel,
    output logic [4:0]       ALUopsel,
    output logic [REG_W-1:0] out_rd,
    output logic             out_wen,
    // debug view of the output-stage state
    output issue_state_t     dbg_state
);

    issue_state_t    state_q, state_d;
    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] wb_mask, set_mask, pend_eff;
    logic [XLEN-1:0] rdata_a, rdata_b;
    logic            hazard, accept;

    reg_file #(.NREG(NREG)) u_reg_file (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr_a (in_rs),
        .rdata_a (rdata_a),
        .raddr_b (in_rt),
        .rdata_b (rdata_b),
        .wen     (wb_valid),
        .waddr   (wb_rd),
        .wdata   (wb_data)
    );

    // Scoreboard masks: this cycle's writeback clear and acceptance set
    always_comb begin
        wb_mask  = '0;
        set_mask = '0;
        for (int i = 1; i < NREG; i++) begin
            wb_mask[i]  = wb_valid && (wb_rd == REG_W'(i));
            set_mask[i] = accept && in_wen && (in_rd == REG_W'(i));
        end
        // A register being written back right now no longer blocks issue
        pend_eff = pending_q & ~wb_mask;
    end

    // Hazard detection (RAW on both sources, WAW on destination) and accept
    always_comb begin
        hazard = (in_rs != '0 && pend_eff[in_rs])
              || (!in_use_imm && in_rt != '0 && pend_eff[in_rt])
              || (in_wen && in_rd != '0 && pend_eff[in_rd]);
        // rst_n gating keeps in_ready low while the block is held in reset
        in_ready = rst_n && (state_q == ST_EMPTY || out_ready) && !hazard;
        accept   = in_valid && in_ready;
    end

    // Pending bits: set on acceptance wins over a same-index writeback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~wb_mask) | set_mask;
        end
    end

    // Output-stage state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output-stage next state: accept fills, consume without accept drains
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL: begin
                if (accept)         state_d = ST_FULL;
                else if (out_ready) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Output payload: operands sampled once at acceptance, then held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALU_A    <= '0;
            ALU_B    <= '0;
            ALUipsel <= 1'b0;
            ALUopsel <= '0;
            out_rd   <= '0;
            out_wen  <= 1'b0;
        end else if (accept) begin
            ALU_A    <= rdata_a;
            ALU_B    <= in_use_imm ? in_imm : rdata_b;
            ALUipsel <= in_alusel;
            ALUopsel <= in_aluop;
            out_rd   <= in_rd;
            out_wen  <= in_wen;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign dbg_state = state_q;

endmodule
